matvec_engine: RTL and testbench
================================

Name: matvec_engine

Overview:
- Parametrised N x N matrix-times-vector engine on CLOCK_50.
- Fetches matrix A (N rows) and vector B (1 row) from a word-per-row memory port, then computes all N dot products in parallel, one column per cycle.
- Results are held in a readable result bank.
- Adds N/width generality, a signed mode, saturating accumulation with sticky overflow flags, and a start/busy/done handshake.

Parameters:
- N, 8, matrix dimension (rows = columns = vector length); power of two, 2..16.
- DATA_W, 8, element width in bits.
- ACC_W, 24, accumulator/result width; must be at least 2*DATA_W.
- ADDR_W, 32, memory word address width.
- SIGNED, 0, 0 = unsigned operands/results, 1 = two's-complement operands/results.
- B_ADDR, N, word address of vector B; A row r is at word address r.

Ports:
- CLOCK_50  in  1  clock.
- rst_n  in  1  reset.
- start  in  1  start request, sampled when idle.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse when results are valid.
- mem_address  out  ADDR_W  word address.
- mem_read  out  1  read request.
- mem_readdata  in  N*DATA_W  row word; column 0 in the MSBs.
- mem_readdatavalid  in  1  read data valid.
- mem_waitrequest  in  1  memory stall.
- res_sel  in  $clog2(N)  result index.
- res_data  out  ACC_W  result[res_sel], combinational.
- overflow  out  N  sticky per-row saturation flags.

Behaviour:
- Reset is rst_n, asynchronous, active-low; clock is CLOCK_50.
- Reset values: state IDLE; busy=0, done=0, mem_read=0, mem_address=0, overflow=0. All accumulators, A buffer, B buffer and row counter are 0, so res_data=0.
- States: IDLE, FETCH, WAIT_DATA, COMPUTE, DONE.
- IDLE:
  - start=1 -> FETCH, row counter=0, accumulators and overflow cleared, busy=1.
  - start is ignored in every other state.
- FETCH:
  - mem_read=1, mem_address = row counter (0..N-1), or B_ADDR when row counter=N.
  - A read is accepted on the edge where mem_read=1 and mem_waitrequest=0; then -> WAIT_DATA, mem_read=0.
  - While mem_waitrequest=1, address and read are held stable; exactly one read is issued per word.
- WAIT_DATA:
  - On mem_readdatavalid=1, capture the word. Row counter<N: into A row buffer[row]. Row counter=N: into B buffer.
  - Then increment the row counter and go to FETCH, or to COMPUTE after the B word.
  - mem_readdatavalid is ignored in all other states.
  - One outstanding read maximum.
- COMPUTE:
  - Column counter c runs 0..N-1, one cycle each.
  - For every row r in parallel: acc[r] <= sat(acc[r] + A[r][c]*B[c]).
  - Product is 2*DATA_W wide; sign-extended if SIGNED=1, zero-extended otherwise, to ACC_W+1 before the add.
  - sat clamps to max/min representable ACC_W value (unsigned: 2^ACC_W-1; signed: +/-). On clamp, overflow[r] <= 1 (sticky until next start).
  - Once saturated, an accumulator stays clamped unless a later term brings the true sum back in range. Saturation applies per step, not only on the final sum.
  - After c=N-1 -> DONE.
- DONE: done=1 for exactly one cycle, busy=0, then -> IDLE. Results and overflow are held until the next accepted start.
- Latency with mem_waitrequest=0 and mem_readdatavalid one cycle after acceptance (start-sample cycle = 0):
  - Each word takes 2 cycles: cycles 1..2(N+1).
  - COMPUTE occupies N cycles.
  - done is high in cycle 3N+3 (27 for N=8).
  - Each waitrequest stall cycle or extra readdatavalid delay cycle adds 1.
- res_data is valid for any res_sel at any time; mid-run it shows partial sums.
- Reset mid-operation: immediate return to reset values; an in-flight memory response arriving after reset is ignored.
- start held high continuously: a new run begins the cycle after DONE, i.e. in IDLE.

Test Plan:
- N=8 unsigned; A=identity, B=1..8 -> done at cycle 27, res_data[r]=r+1, overflow=0.
- N=8 unsigned; all A and B = 0xFF -> every res_data=520200 (0x07F008), overflow=0.
- ACC_W=16 instance; all A and B = 0xFF -> every res_data=0xFFFF, overflow=0xFF, done still at cycle 27.
- SIGNED=1, N=4, ACC_W=24; A row0 = {-1,2,-3,4}, B={1,1,1,1} -> res_data[0]=2 (0x000002). A row1 all 0x80, B all 0x80 -> res_data[1]=65536.
- mem_waitrequest=1 for 5 cycles on row 3's read -> mem_address=3 and mem_read held stable all 5 cycles, one acceptance only; done delayed by exactly 5 cycles; results correct.
- Pulse start while busy -> no effect. Assert rst_n=0 during COMPUTE -> busy=0, res_data=0, overflow=0 immediately. A fresh start then gives the correct results.

Source files
------------

// File: rtl/matvec_engine.sv
// rtl/matvec_engine.sv - N x N matrix-vector engine: fetches A and B row words, accumulates A*B with saturation
module matvec_engine #(
    parameter int N      = 8,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24,
    parameter int ADDR_W = 32,
    parameter int SIGNED = 0,
    parameter int B_ADDR = N
) (
    input  logic                   CLOCK_50,
    input  logic                   rst_n,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic [ADDR_W-1:0]      mem_address,
    output logic                   mem_read,
    input  logic [N*DATA_W-1:0]    mem_readdata,
    input  logic                   mem_readdatavalid,
    input  logic                   mem_waitrequest,
    input  logic [$clog2(N)-1:0]   res_sel,
    output logic [ACC_W-1:0]       res_data,
    output logic [N-1:0]           overflow
);

    localparam int CW = $clog2(N);
    localparam int RW = CW + 1;
    localparam int WW = N * DATA_W;
    localparam int PW = 2 * DATA_W;
    localparam int XW = ACC_W + 1;
    localparam logic [RW-1:0] ROW_B    = RW'(N);
    localparam logic [CW-1:0] COL_LAST = CW'(N - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT_DATA,
        COMPUTE,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [RW-1:0]     row_q, row_d;
    logic [CW-1:0]     col_q, col_d;
    logic [WW-1:0]     a_q [N];
    logic [WW-1:0]     a_d [N];
    logic [WW-1:0]     b_q, b_d;
    logic [ACC_W-1:0]  acc_q [N];
    logic [ACC_W-1:0]  acc_d [N];
    logic [ACC_W-1:0]  sat_w [N];
    logic [N-1:0]      ovf_q, ovf_d, clamp_w;
    logic [CW-1:0]     col_rev;
    logic [DATA_W-1:0] b_el;

    // Column 0 sits in the MSBs, so the bit offset counts down as c counts up.
    assign col_rev = COL_LAST - col_q;
    assign b_el    = b_q[int'(col_rev)*DATA_W +: DATA_W];

    for (genvar r = 0; r < N; r++) begin : g_row
        logic [DATA_W-1:0] a_el;
        logic [PW-1:0]     ax, bx, prod;
        logic [XW-1:0]     sum;

        assign a_el = a_q[r][int'(col_rev)*DATA_W +: DATA_W];
        if (SIGNED != 0) begin : g_s
            assign ax   = {{DATA_W{a_el[DATA_W-1]}}, a_el};
            assign bx   = {{DATA_W{b_el[DATA_W-1]}}, b_el};
            assign prod = ax * bx;
            assign sum  = {{(XW-PW){prod[PW-1]}}, prod} + {acc_q[r][ACC_W-1], acc_q[r]};
            // Top two bits disagree exactly when the true sum left the ACC_W signed range.
            assign clamp_w[r] = sum[XW-1] ^ sum[XW-2];
            assign sat_w[r]   = !clamp_w[r] ? sum[ACC_W-1:0] :
                                sum[XW-1]   ? {1'b1, {(ACC_W-1){1'b0}}} :
                                              {1'b0, {(ACC_W-1){1'b1}}};
        end else begin : g_u
            assign ax   = {{DATA_W{1'b0}}, a_el};
            assign bx   = {{DATA_W{1'b0}}, b_el};
            assign prod = ax * bx;
            assign sum  = {{(XW-PW){1'b0}}, prod} + {1'b0, acc_q[r]};
            assign clamp_w[r] = sum[ACC_W];
            assign sat_w[r]   = clamp_w[r] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
        end
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            b_q     <= '0;
            ovf_q   <= '0;
            for (int i = 0; i < N; i++) begin
                a_q[i]   <= '0;
                acc_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            b_q     <= b_d;
            ovf_q   <= ovf_d;
            for (int i = 0; i < N; i++) begin
                a_q[i]   <= a_d[i];
                acc_q[i] <= acc_d[i];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        b_d         = b_q;
        ovf_d       = ovf_q;
        a_d         = a_q;
        acc_d       = acc_q;
        busy        = 1'b0;
        done        = 1'b0;
        mem_read    = 1'b0;
        mem_address = '0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                    row_d   = '0;
                    col_d   = '0;
                    ovf_d   = '0;
                    for (int i = 0; i < N; i++) acc_d[i] = '0;
                end
            end
            FETCH: begin
                busy        = 1'b1;
                mem_read    = 1'b1;
                mem_address = (row_q == ROW_B) ? ADDR_W'(B_ADDR) : ADDR_W'(row_q);
                if (!mem_waitrequest) state_d = WAIT_DATA;
            end
            WAIT_DATA: begin
                busy = 1'b1;
                if (mem_readdatavalid) begin
                    if (row_q == ROW_B) begin
                        b_d     = mem_readdata;
                        col_d   = '0;
                        state_d = COMPUTE;
                    end else begin
                        a_d[row_q[CW-1:0]] = mem_readdata;
                        row_d   = row_q + 1'b1;
                        state_d = FETCH;
                    end
                end
            end
            COMPUTE: begin
                busy = 1'b1;
                for (int i = 0; i < N; i++) begin
                    acc_d[i] = sat_w[i];
                    if (clamp_w[i]) ovf_d[i] = 1'b1;
                end
                col_d = col_q + 1'b1;
                if (col_q == COL_LAST) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign res_data = acc_q[res_sel];
    assign overflow = ovf_q;

endmodule

// File: tb/tb_matvec_engine.sv
// tb/tb_matvec_engine.sv - randomized self-checking bench for matvec_engine against an arithmetic model
module tb_matvec_engine;

    logic clk = 1'b0;
    logic rst_n;
    always #10 clk = ~clk;

    logic        start_m, busy_m, done_m, mem_read_m, rdv_m, wr_m;
    logic [31:0] addr_m;
    logic [63:0] rd_m;
    logic [2:0]  sel_m;
    logic [23:0] res_m;
    logic [7:0]  ovf_m;

    logic        start_s, busy_s, done_s, mem_read_s, rdv_s;
    logic [31:0] addr_s;
    logic [63:0] rd_s;
    logic [2:0]  sel_s;
    logic [15:0] res_s;
    logic [7:0]  ovf_s;

    logic        start_g, busy_g, done_g, mem_read_g, rdv_g;
    logic [31:0] addr_g;
    logic [31:0] rd_g;
    logic [1:0]  sel_g;
    logic [23:0] res_g;
    logic [3:0]  ovf_g;

    matvec_engine #(.N(8), .DATA_W(8), .ACC_W(24)) u_dut (
        .CLOCK_50(clk), .rst_n(rst_n), .start(start_m), .busy(busy_m), .done(done_m),
        .mem_address(addr_m), .mem_read(mem_read_m), .mem_readdata(rd_m),
        .mem_readdatavalid(rdv_m), .mem_waitrequest(wr_m),
        .res_sel(sel_m), .res_data(res_m), .overflow(ovf_m)
    );

    matvec_engine #(.N(8), .DATA_W(8), .ACC_W(16)) u_sat (
        .CLOCK_50(clk), .rst_n(rst_n), .start(start_s), .busy(busy_s), .done(done_s),
        .mem_address(addr_s), .mem_read(mem_read_s), .mem_readdata(rd_s),
        .mem_readdatavalid(rdv_s), .mem_waitrequest(1'b0),
        .res_sel(sel_s), .res_data(res_s), .overflow(ovf_s)
    );

    matvec_engine #(.N(4), .DATA_W(8), .ACC_W(24), .SIGNED(1)) u_sgn (
        .CLOCK_50(clk), .rst_n(rst_n), .start(start_g), .busy(busy_g), .done(done_g),
        .mem_address(addr_g), .mem_read(mem_read_g), .mem_readdata(rd_g),
        .mem_readdatavalid(rdv_g), .mem_waitrequest(1'b0),
        .res_sel(sel_g), .res_data(res_g), .overflow(ovf_g)
    );

    int     n_chk = 0;
    int     n_fail = 0;
    int     ma [16][16];
    int     mb [16];
    longint exp_res [16];
    int     exp_ovf;
    logic [63:0] mem_m [0:15];
    logic [63:0] mem_s [0:15];
    logic [31:0] mem_g [0:15];
    int     acc_cnt, addr_err, stab_err, stall_n, stall_at;
    bit     rnd;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: plain integer dot products, clamped after every term.
    function automatic void model(input int n, input int accw, input bit sgn);
        longint mx, mn, s, a, b;
        mx = sgn ? (longint'(1) << (accw - 1)) - 1 : (longint'(1) << accw) - 1;
        mn = sgn ? -(longint'(1) << (accw - 1)) : 0;
        exp_ovf = 0;
        for (int r = 0; r < n; r++) begin
            s = 0;
            for (int c = 0; c < n; c++) begin
                a = (sgn && ma[r][c] >= 128) ? ma[r][c] - 256 : ma[r][c];
                b = (sgn && mb[c] >= 128) ? mb[c] - 256 : mb[c];
                s = s + a * b;
                if (s > mx) begin s = mx; exp_ovf |= (1 << r); end
                else if (s < mn) begin s = mn; exp_ovf |= (1 << r); end
            end
            exp_res[r] = s & ((longint'(1) << accw) - 1);
        end
    endfunction

    function automatic logic [63:0] pack(input int row, input int n);
        logic [63:0] w = '0;
        for (int c = 0; c < n; c++)
            w = (w << 8) | 64'(row == n ? mb[c] : ma[row][c]);
        return w;
    endfunction

    task automatic load(input int which, input int n);
        logic [63:0] w;
        for (int i = 0; i <= n; i++) begin
            w = pack(i, n);
            case (which)
                0: mem_m[i] = w;
                1: mem_s[i] = w;
                default: mem_g[i] = w[31:0];
            endcase
        end
    endtask

    task automatic fill_rand(input int n, input int lim);
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++) ma[r][c] = $urandom_range(0, lim);
        for (int c = 0; c < n; c++) mb[c] = $urandom_range(0, lim);
    endtask

    task automatic fill_const(input int n, input int v);
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++) ma[r][c] = v;
        for (int c = 0; c < n; c++) mb[c] = v;
    endtask

    function automatic logic get_done(input int which);
        case (which)
            0: return done_m;
            1: return done_s;
            default: return done_g;
        endcase
    endfunction

    function automatic logic get_busy(input int which);
        case (which)
            0: return busy_m;
            1: return busy_s;
            default: return busy_g;
        endcase
    endfunction

    function automatic longint get_res(input int which);
        case (which)
            0: return longint'(res_m);
            1: return longint'(res_s);
            default: return longint'(res_g);
        endcase
    endfunction

    function automatic longint get_ovf(input int which);
        case (which)
            0: return longint'(ovf_m);
            1: return longint'(ovf_s);
            default: return longint'(ovf_g);
        endcase
    endfunction

    task automatic set_start(input int which, input logic v);
        case (which)
            0: start_m = v;
            1: start_s = v;
            default: start_g = v;
        endcase
    endtask

    // cyc counts cycles after the start-sample cycle (cycle 0).
    task automatic run(input int which, input bit pulse_mid, output int cyc);
        acc_cnt = 0; addr_err = 0; stab_err = 0;
        @(posedge clk); #1; set_start(which, 1'b1);
        @(posedge clk); #1; set_start(which, 1'b0);
        cyc = 1;
        while (!get_done(which) && cyc < 500) begin
            @(posedge clk); #1;
            cyc++;
            set_start(which, pulse_mid && cyc >= 10 && cyc <= 12);
        end
        set_start(which, 1'b0);
        chk("done_seen", get_done(which), 1);
        chk("busy_at_done", get_busy(which), 0);
        @(posedge clk); #1;
        chk("done_one_cycle", get_done(which), 0);
    endtask

    task automatic check_res(input int which, input int n, input string tag);
        for (int r = 0; r < n; r++) begin
            sel_m = 3'(r); sel_s = 3'(r); sel_g = 2'(r);
            #1;
            chk($sformatf("%s_res%0d", tag, r), get_res(which), exp_res[r]);
        end
        chk({tag, "_ovf"}, get_ovf(which), longint'(exp_ovf));
    endtask

    // Memory for the main instance: optional directed stall, optional random stalls and latency.
    initial begin : resp_m
        logic        hit, was_stall;
        logic [31:0] a_hit, a_stall;
        logic [63:0] pdata;
        bit          pend;
        int          dly;
        rdv_m = 0; wr_m = 0; rd_m = '0; pend = 0; dly = 0;
        hit = 0; was_stall = 0; a_hit = '0; a_stall = '0; pdata = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hit = 0; was_stall = 0; pend = 0;
            end else begin
                if (was_stall && !(mem_read_m && addr_m == a_stall)) stab_err++;
                hit       = mem_read_m && !wr_m;
                a_hit     = addr_m;
                was_stall = mem_read_m && wr_m;
                a_stall   = addr_m;
            end
            @(posedge clk); #1;
            rdv_m = 0;
            if (hit) begin
                if (a_hit != 32'(acc_cnt)) addr_err++;
                acc_cnt++;
                pend  = 1;
                dly   = rnd ? $urandom_range(0, 2) : 0;
                pdata = mem_m[a_hit[3:0]];
            end
            if (pend) begin
                if (dly == 0) begin rdv_m = 1; rd_m = pdata; pend = 0; end
                else dly--;
            end
            wr_m = 0;
            if (mem_read_m) begin
                if (stall_n > 0 && addr_m == 32'(stall_at)) begin wr_m = 1; stall_n--; end
                else if (rnd) wr_m = ($urandom_range(0, 2) == 0);
            end
        end
    end

    initial begin : resp_s
        logic        hit;
        logic [31:0] a;
        rdv_s = 0; rd_s = '0;
        forever begin
            @(negedge clk);
            hit = mem_read_s && rst_n;
            a   = addr_s;
            @(posedge clk); #1;
            rdv_s = hit;
            if (hit) rd_s = mem_s[a[3:0]];
        end
    end

    initial begin : resp_g
        logic        hit;
        logic [31:0] a;
        rdv_g = 0; rd_g = '0;
        forever begin
            @(negedge clk);
            hit = mem_read_g && rst_n;
            a   = addr_g;
            @(posedge clk); #1;
            rdv_g = hit;
            if (hit) rd_g = mem_g[a[3:0]];
        end
    end

    initial begin : stim
        int cyc;
        int lims [3] = '{15, 127, 255};
        rst_n = 0; start_m = 0; start_s = 0; start_g = 0;
        sel_m = 0; sel_s = 0; sel_g = 0;
        rnd = 0; stall_n = 0; stall_at = 99;
        acc_cnt = 0; addr_err = 0; stab_err = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy_m, 0);
        chk("rst_done", done_m, 0);
        chk("rst_mem_read", mem_read_m, 0);
        chk("rst_mem_address", addr_m, 0);
        for (int r = 0; r < 16; r++) exp_res[r] = 0;
        exp_ovf = 0;
        check_res(0, 8, "rst");
        rst_n = 1;

        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) ma[r][c] = (r == c) ? 1 : 0;
            mb[r] = r + 1;
        end
        model(8, 24, 0); load(0, 8);
        run(0, 0, cyc);
        chk("id_cycles", cyc, 27);
        chk("id_accepts", acc_cnt, 9);
        chk("id_addr_order", addr_err, 0);
        check_res(0, 8, "id");

        fill_const(8, 255); model(8, 24, 0); load(0, 8);
        run(0, 0, cyc);
        chk("ff_cycles", cyc, 27);
        check_res(0, 8, "ff");
        sel_m = 3'd5; #1;
        chk("ff_row5_value", res_m, 520200);

        fill_rand(8, 255); model(8, 24, 0); load(0, 8);
        stall_at = 3; stall_n = 5;
        run(0, 0, cyc);
        chk("stall_cycles", cyc, 32);
        chk("stall_addr_stable", stab_err, 0);
        chk("stall_accepts", acc_cnt, 9);
        chk("stall_addr_order", addr_err, 0);
        check_res(0, 8, "stall");
        stall_at = 99;

        fill_rand(8, 255); model(8, 24, 0); load(0, 8);
        run(0, 1, cyc);
        chk("busy_start_cycles", cyc, 27);
        check_res(0, 8, "busy_start");

        rnd = 1;
        for (int k = 0; k < 4; k++) begin
            fill_rand(8, lims[$urandom_range(0, 2)]); model(8, 24, 0); load(0, 8);
            run(0, 0, cyc);
            chk("rnd_accepts", acc_cnt, 9);
            chk("rnd_addr_order", addr_err, 0);
            check_res(0, 8, $sformatf("rnd%0d", k));
        end
        rnd = 0;

        fill_const(8, 255); model(8, 16, 0); load(1, 8);
        run(1, 0, cyc);
        chk("sat_cycles", cyc, 27);
        check_res(1, 8, "sat");
        sel_s = 3'd2; #1;
        chk("sat_row2_value", res_s, 16'hFFFF);
        chk("sat_ovf_value", ovf_s, 8'hFF);
        for (int k = 0; k < 3; k++) begin
            fill_rand(8, lims[k]); model(8, 16, 0); load(1, 8);
            run(1, 0, cyc);
            check_res(1, 8, $sformatf("sat_rnd%0d", k));
        end

        fill_rand(4, 255);
        ma[0][0] = 8'hFF; ma[0][1] = 2; ma[0][2] = 8'hFD; ma[0][3] = 4;
        for (int c = 0; c < 4; c++) begin ma[1][c] = 8'h80; mb[c] = 1; end
        model(4, 24, 1); load(2, 4);
        run(2, 0, cyc);
        chk("sgn_cycles", cyc, 15);
        check_res(2, 4, "sgn_b1");
        sel_g = 2'd0; #1;
        chk("sgn_row0_value", res_g, 2);
        for (int c = 0; c < 4; c++) mb[c] = 8'h80;
        model(4, 24, 1); load(2, 4);
        run(2, 0, cyc);
        check_res(2, 4, "sgn_b80");
        sel_g = 2'd1; #1;
        chk("sgn_row1_value", res_g, 65536);
        for (int k = 0; k < 3; k++) begin
            fill_rand(4, 255); model(4, 24, 1); load(2, 4);
            run(2, 0, cyc);
            check_res(2, 4, $sformatf("sgn_rnd%0d", k));
        end

        fill_rand(8, 255); load(0, 8);
        @(posedge clk); #1; start_m = 1;
        @(posedge clk); #1; start_m = 0;
        repeat (21) @(posedge clk);
        #4;
        rst_n = 0;
        #1;
        chk("midrst_busy", busy_m, 0);
        chk("midrst_mem_read", mem_read_m, 0);
        for (int r = 0; r < 16; r++) exp_res[r] = 0;
        exp_ovf = 0;
        check_res(0, 8, "midrst");
        @(posedge clk); #1;
        rst_n = 1;
        model(8, 24, 0);
        run(0, 0, cyc);
        chk("after_rst_cycles", cyc, 27);
        check_res(0, 8, "after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
